// File: rtl/pts_reg.sv
// pts_reg: parallel-to-serial transmitter with a one-word holding buffer; even parity bit optional via PTS_PARITY_EN
module pts_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              tx_start,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);
`ifdef PTS_PARITY_EN
  typedef enum logic [1:0] {IDLE, START, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, SHIFT} state_t;
`endif
  state_t            state_q, state_d;
  logic              buf_full_q, buf_full_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] load_data;
  logic              accept, bypass, last_bit, frame_end, load;
`ifdef PTS_PARITY_EN
  logic              par_q, par_d;
`endif
  assign s_ready   = !buf_full_q;
  assign accept    = s_valid && s_ready;
  assign last_bit  = (state_q == SHIFT) && (bit_cnt_q == '0);
`ifdef PTS_PARITY_EN
  assign frame_end = (state_q == PARITY);
  assign done      = frame_end;
  assign tx_out    = (state_q == SHIFT) ? shreg_q[DATA_W-1] : (state_q == PARITY) ? par_q : 1'b0;
`else
  assign frame_end = last_bit;
  assign done      = last_bit;
  assign tx_out    = (state_q == SHIFT) ? shreg_q[DATA_W-1] : 1'b0;
`endif
  // An accept while idle goes straight into the shifter so tx_start follows on the very next cycle.
  assign bypass    = (state_q == IDLE) && !buf_full_q && s_valid;
  assign load      = (((state_q == IDLE) || frame_end) && buf_full_q) || bypass;
  assign load_data = buf_full_q ? buf_data_q : s_data;
  assign tx_start  = (state_q == START);
  assign busy      = (state_q != IDLE) || buf_full_q;
  // Next-state, buffer and shifter updates; a frame end with a full buffer reloads with no gap.
  always_comb begin
    state_d    = load ? START : frame_end ? IDLE : (state_q == START) ? SHIFT :
`ifdef PTS_PARITY_EN
                 last_bit ? PARITY :
`endif
                 state_q;
    buf_full_d = (accept && !bypass) ? 1'b1 : load ? 1'b0 : buf_full_q;
    buf_data_d = accept ? s_data : buf_data_q;
    shreg_d    = load ? load_data : (state_q == SHIFT) ? shreg_q << 1 : shreg_q;
    bit_cnt_d  = load ? CNT_W'(DATA_W - 1) : (state_q == SHIFT) ? bit_cnt_q - CNT_W'(1) : bit_cnt_q;
`ifdef PTS_PARITY_EN
    par_d      = load ? ^load_data : par_q;
`endif
  end
  // State registers with synchronous active-low reset that aborts any frame and drops the buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      buf_full_q <= 1'b0;
      buf_data_q <= '0;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
`ifdef PTS_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      buf_full_q <= buf_full_d;
      buf_data_q <= buf_data_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
`ifdef PTS_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end
endmodule

// File: tb/tb_pts_reg.sv
// tb_pts_reg: directed bench for pts_reg with a behavioural receiver feeding a word scoreboard
module tb_pts_reg;
  localparam int W = 32;
`ifdef PTS_PARITY_EN
  localparam int DONE_LAT = W + 2;
  localparam int PERIOD   = W + 2;
`else
  localparam int DONE_LAT = W + 1;
  localparam int PERIOD   = W + 1;
`endif
  logic         clk, rst_n, s_valid, s_ready, tx_start, tx_out, busy, done;
  logic [W-1:0] s_data;
  logic [W-1:0] q[$];
  logic [W-1:0] rx_word;
  int           checks, errors, cyc, rx_cnt, starts, dones, last_start, last_done;
  logic         rx_active, par_ph;

  pts_reg #(.DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .tx_start(tx_start), .tx_out(tx_out), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_cmp(input logic [W-1:0] w);
    chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
    if (q.size() != 0) chk("frame_word", w, q.pop_front());
  endtask

  task automatic mon();
    logic ed;
    ed = 1'b0;
    if (par_ph) begin
      ed = 1'b1;
      par_ph = 1'b0;
      chk("parity_bit", 32'(tx_out), 32'(^rx_word));
      pop_cmp(rx_word);
    end else if (rx_active && !tx_start) begin
      rx_word = {rx_word[W-2:0], tx_out};
      if (rx_cnt == W - 1) begin
        rx_active = 1'b0;
`ifdef PTS_PARITY_EN
        par_ph = 1'b1;
`else
        ed = 1'b1;
        pop_cmp(rx_word);
`endif
      end
      rx_cnt++;
    end
    if (tx_start) begin
      chk("start_tx_out_low", 32'(tx_out), 32'd0);
      rx_active = 1'b1;
      rx_cnt = 0;
      rx_word = '0;
      starts++;
      last_start = cyc;
    end
    chk("done", 32'(done), 32'(ed));
    if (done) begin
      dones++;
      last_done = cyc;
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    mon();
  endtask

  task automatic send(input logic [W-1:0] w, output int acc);
    s_data = w;
    s_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 100 && acc < 0; i++) begin
      if (s_ready) begin
        q.push_back(w);
        acc = cyc;
      end
      step();
    end
    s_valid = 1'b0;
    chk("accept_timeout", 32'(acc >= 0), 32'd1);
  endtask

  task automatic wait_done();
    int d0;
    d0 = dones;
    for (int i = 0; i < 100 && dones == d0; i++) step();
    chk("done_timeout", 32'(dones != d0), 32'd1);
  endtask

  task automatic idle_outs(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd1);
    chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    chk({tag, "_tx_out"}, 32'(tx_out), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int a, b, s1, st0, d0;
    checks = 0; errors = 0; cyc = 0; rx_cnt = 0; starts = 0; dones = 0;
    last_start = 0; last_done = 0; rx_active = 1'b0; par_ph = 1'b0; rx_word = '0;
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0;
    step();
    step();
    idle_outs("in_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      idle_outs("post_reset");
    end

    send(32'hA5F0_0F5A, a);
    chk("single_start_cycle", 32'(last_start), 32'(a + 1));
    wait_done();
    chk("single_done_cycle", 32'(last_done), 32'(a + DONE_LAT));
    chk("single_one_start", 32'(starts), 32'd1);
    step();
    idle_outs("single_idle");

    send(32'hDEAD_BEEF, a);
    wait_done();
    chk("loopback_done_cycle", 32'(last_done), 32'(a + DONE_LAT));
    step();

    send(32'hFFFF_FFFF, a);
    s1 = last_start;
    send(32'h0000_0001, b);
    chk("b2b_accept_in_start", 32'(b), 32'(s1));
    st0 = starts;
    for (int i = 0; i < 100 && starts == st0; i++) begin
      chk("b2b_ready_low_full", 32'(s_ready), 32'd0);
      step();
    end
    chk("b2b_second_start", 32'(starts), 32'(st0 + 1));
    chk("b2b_no_gap", 32'(last_start), 32'(last_done + 1));
    chk("b2b_period", 32'(last_start - s1), 32'(PERIOD));
    wait_done();
    step();
    chk("b2b_sb_empty", 32'(q.size()), 32'd0);
    idle_outs("b2b_idle");

    send(32'h1234_5678, a);
    send(32'hCAFE_F00D, b);
    for (int i = 0; i < 100 && !(rx_active && rx_cnt == 16); i++) step();
    chk("mid_reached_bit16", 32'(rx_cnt), 32'd16);
    rst_n = 1'b0;
    q.delete();
    rx_active = 1'b0;
    par_ph = 1'b0;
    st0 = starts;
    d0 = dones;
    step();
    idle_outs("mid_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) step();
    chk("mid_no_restart", 32'(starts), 32'(st0));
    chk("mid_no_done", 32'(dones), 32'(d0));
    idle_outs("mid_idle");

`ifdef PTS_PARITY_EN
    send(32'h0000_0007, a);
    wait_done();
    chk("parity_done_cycle", 32'(last_done), 32'(a + W + 2));
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
